// File: rtl/hazard_ctrl_ppl_if.sv
// ID/EX-side signal bundle between the pipeline datapath and the hazard
// controller: decoded ID fields in, stall/flush/forward controls out.
interface hazard_ctrl_ppl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_wr;
    logic [4:0] id_wdst;
    logic       id_is_load;
    logic       id_md_start;
    logic       id_rd_hilo;
    logic       ex_br_taken;
    logic       stall;
    logic       flush_ifid;
    logic       flush_idex;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       md_busy;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_wr, id_wdst,
               id_is_load, id_md_start, id_rd_hilo, ex_br_taken,
        input  stall, flush_ifid, flush_idex, fwd_a, fwd_b, md_busy
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_wr, id_wdst,
               id_is_load, id_md_start, id_rd_hilo, ex_br_taken,
        output stall, flush_ifid, flush_idex, fwd_a, fwd_b, md_busy
    );
endinterface

// File: rtl/hazard_ctrl_ppl.sv
// Five-stage pipeline hazard controller: in-flight write scoreboard,
// operand forwarding selects, load-use stalls, branch flushes and the
// HI/LO multiply/divide busy tracker.
module hazard_ctrl_ppl #(
    parameter int unsigned MD_LAT = 32
) (
    input  logic            clk,
    input  logic            reset,
    hazard_ctrl_ppl_if.slave hz
);

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_t;

    localparam logic [5:0] MD_LOAD = 6'(MD_LAT - 1);

    // WB results are readable from the register file in the same cycle
    // (negedge write) and never forward, so only EX and MEM are stored.
    logic       ex_v, ex_ld, mem_v, mem_ld;
    logic [4:0] ex_dst, mem_dst;

    md_state_t  md_state, md_next;
    logic [5:0] md_cnt, md_cnt_next;

    logic ex_rs, ex_rt, mem_rs, mem_rt;
    logic load_use, md_hazard;
    logic stall_int, flush_ifid_int, flush_idex_int;
    logic [1:0] fwd_a_int, fwd_b_int;
    logic md_busy_int;

    // Match the ID source operands against the older in-flight writers.
    always_comb begin
        ex_rs  = hz.id_use_rs && (hz.id_rs != 5'd0) && ex_v  && (ex_dst  == hz.id_rs);
        ex_rt  = hz.id_use_rt && (hz.id_rt != 5'd0) && ex_v  && (ex_dst  == hz.id_rt);
        mem_rs = hz.id_use_rs && (hz.id_rs != 5'd0) && mem_v && (mem_dst == hz.id_rs);
        mem_rt = hz.id_use_rt && (hz.id_rt != 5'd0) && mem_v && (mem_dst == hz.id_rt);
    end

    // Stall/flush decisions; a taken branch discards ID so it overrides stalls.
    always_comb begin
        load_use  = (ex_rs || ex_rt) && ex_ld;
        md_hazard = (md_state == MD_BUSY) && (hz.id_rd_hilo || hz.id_md_start);
        if (hz.ex_br_taken) begin
            stall_int      = 1'b0;
            flush_ifid_int = 1'b1;
            flush_idex_int = 1'b1;
        end else begin
            stall_int      = load_use || md_hazard;
            flush_ifid_int = 1'b0;
            flush_idex_int = load_use || md_hazard;
        end
    end

    // Forward selects: youngest non-load writer in EX wins, else MEM.
    always_comb begin
        fwd_a_int = 2'b00;
        fwd_b_int = 2'b00;
        if (mem_rs) fwd_a_int = 2'b10;
        if (ex_rs && !ex_ld) fwd_a_int = 2'b01;
        if (mem_rt) fwd_b_int = 2'b10;
        if (ex_rt && !ex_ld) fwd_b_int = 2'b01;
    end

    // Scoreboard shift: ID entry enters EX unless a bubble is injected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_v    <= 1'b0;
            ex_dst  <= '0;
            ex_ld   <= 1'b0;
            mem_v   <= 1'b0;
            mem_dst <= '0;
            mem_ld  <= 1'b0;
        end else begin
            ex_v    <= !flush_idex_int && hz.id_wr && (hz.id_wdst != 5'd0);
            ex_dst  <= hz.id_wdst;
            ex_ld   <= hz.id_is_load;
            mem_v   <= ex_v;
            mem_dst <= ex_dst;
            mem_ld  <= ex_ld;
        end
    end

    // Mul/div state register and countdown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_state <= MD_IDLE;
            md_cnt   <= '0;
        end else begin
            md_state <= md_next;
            md_cnt   <= md_cnt_next;
        end
    end

    // Mul/div next state: start only when the ID instruction really advances.
    always_comb begin
        md_next     = md_state;
        md_cnt_next = md_cnt;
        case (md_state)
            MD_IDLE: begin
                if (hz.id_md_start && !stall_int && !flush_idex_int) begin
                    md_next     = MD_BUSY;
                    md_cnt_next = MD_LOAD;
                end
            end
            MD_BUSY: begin
                if (md_cnt == '0) begin
                    md_next = MD_IDLE;
                end else begin
                    md_cnt_next = md_cnt - 6'd1;
                end
            end
            default: md_next = MD_IDLE;
        endcase
    end

    // Mul/div outputs.
    always_comb begin
        md_busy_int = (md_state == MD_BUSY);
    end

    // All controls are held inactive while reset is asserted.
    assign hz.stall      = !reset && stall_int;
    assign hz.flush_ifid = !reset && flush_ifid_int;
    assign hz.flush_idex = !reset && flush_idex_int;
    assign hz.fwd_a      = reset ? 2'b00 : fwd_a_int;
    assign hz.fwd_b      = reset ? 2'b00 : fwd_b_int;
    assign hz.md_busy    = !reset && md_busy_int;

endmodule

// File: tb/tb_hazard_ctrl_ppl.sv
// Self-checking bench for hazard_ctrl_ppl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_hazard_ctrl_ppl;

    localparam int MD_LAT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_ppl_if hz();

    hazard_ctrl_ppl #(.MD_LAT(MD_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    typedef struct {
        logic [4:0] rs, rt, wdst;
        logic urs, urt, wr, ld, md, hilo, br;
    } instr_t;

    typedef struct {
        logic stall, fi, fx, busy;
        logic [1:0] fa, fb;
    } obs_t;

    int errors = 0;
    int checks = 0;

    // Model: history of the last two instructions that entered EX
    // (index 0 = youngest) and remaining busy cycles of the mul/div unit.
    bit       hv[2];
    bit [4:0] hd[2];
    bit       hl[2];
    int       md_rem;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic instr_t nop();
        instr_t i;
        i.rs = 0; i.rt = 0; i.wdst = 0;
        i.urs = 0; i.urt = 0; i.wr = 0; i.ld = 0; i.md = 0; i.hilo = 0; i.br = 0;
        return i;
    endfunction

    function automatic instr_t alu(input int d, input int s, input int t);
        instr_t i = nop();
        i.rs = 5'(s); i.rt = 5'(t); i.urs = 1; i.urt = 1; i.wr = 1; i.wdst = 5'(d);
        return i;
    endfunction

    function automatic instr_t lw(input int d, input int base);
        instr_t i = nop();
        i.rs = 5'(base); i.urs = 1; i.wr = 1; i.wdst = 5'(d); i.ld = 1;
        return i;
    endfunction

    function automatic instr_t mult(input int s, input int t);
        instr_t i = nop();
        i.rs = 5'(s); i.rt = 5'(t); i.urs = 1; i.urt = 1; i.md = 1;
        return i;
    endfunction

    function automatic instr_t mfhi(input int d);
        instr_t i = nop();
        i.hilo = 1; i.wr = 1; i.wdst = 5'(d);
        return i;
    endfunction

    function automatic bit writer_hit(input int age, input logic use_it, input logic [4:0] r);
        return use_it && (r != 0) && hv[age] && (hd[age] == r);
    endfunction

    function automatic logic [1:0] src_sel(input logic use_it, input logic [4:0] r);
        if (writer_hit(0, use_it, r) && !hl[0]) return 2'b01;
        if (writer_hit(1, use_it, r)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic obs_t model(input instr_t i);
        obs_t o;
        bit lu, mh;
        lu = (writer_hit(0, i.urs, i.rs) || writer_hit(0, i.urt, i.rt)) && hl[0];
        mh = (md_rem > 0) && (i.hilo || i.md);
        o.busy = (md_rem > 0);
        if (i.br) begin
            o.stall = 0; o.fi = 1; o.fx = 1;
        end else begin
            o.stall = lu || mh; o.fi = 0; o.fx = lu || mh;
        end
        o.fa = src_sel(i.urs, i.rs);
        o.fb = src_sel(i.urt, i.rt);
        return o;
    endfunction

    task automatic drive(input instr_t i);
        hz.id_rs       = i.rs;
        hz.id_rt       = i.rt;
        hz.id_use_rs   = i.urs;
        hz.id_use_rt   = i.urt;
        hz.id_wr       = i.wr;
        hz.id_wdst     = i.wdst;
        hz.id_is_load  = i.ld;
        hz.id_md_start = i.md;
        hz.id_rd_hilo  = i.hilo;
        hz.ex_br_taken = i.br;
    endtask

    task automatic clear_model();
        hv[0] = 0; hv[1] = 0; hd[0] = 0; hd[1] = 0; hl[0] = 0; hl[1] = 0;
        md_rem = 0;
    endtask

    // One pipeline cycle: entered at posedge+1, compares mid-cycle against
    // the model, then advances the model on the edge.
    task automatic cyc(input instr_t i, output obs_t got);
        obs_t e;
        drive(i);
        e = model(i);
        #3;
        got.stall = hz.stall;
        got.fi    = hz.flush_ifid;
        got.fx    = hz.flush_idex;
        got.busy  = hz.md_busy;
        got.fa    = hz.fwd_a;
        got.fb    = hz.fwd_b;
        check("stall", 32'(got.stall), 32'(e.stall));
        check("flush_ifid", 32'(got.fi), 32'(e.fi));
        check("flush_idex", 32'(got.fx), 32'(e.fx));
        check("md_busy", 32'(got.busy), 32'(e.busy));
        check("fwd_a", 32'(got.fa), 32'(e.fa));
        check("fwd_b", 32'(got.fb), 32'(e.fb));
        @(posedge clk);
        if (md_rem > 0) md_rem--;
        else if (i.md && !e.fx) md_rem = MD_LAT;
        hv[1] = hv[0]; hd[1] = hd[0]; hl[1] = hl[0];
        hv[0] = !e.fx && i.wr && (i.wdst != 0);
        hd[0] = i.wdst;
        hl[0] = i.ld;
        #1;
    endtask

    // Present one instruction until it is no longer stalled (bounded).
    task automatic issue(input instr_t i, output int stalls, output obs_t last);
        bit done = 0;
        stalls = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            cyc(i, last);
            if (!last.stall) done = 1;
            else stalls++;
        end
        if (!done) check("issue_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(nop());
        #1;
        check("rst_stall", 32'(hz.stall), 32'd0);
        check("rst_flush_ifid", 32'(hz.flush_ifid), 32'd0);
        check("rst_flush_idex", 32'(hz.flush_idex), 32'd0);
        check("rst_fwd_a", 32'(hz.fwd_a), 32'd0);
        check("rst_fwd_b", 32'(hz.fwd_b), 32'd0);
        check("rst_md_busy", 32'(hz.md_busy), 32'd0);
        clear_model();
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n);
        obs_t o;
        for (int k = 0; k < n; k++) cyc(nop(), o);
    endtask

    initial begin
        obs_t o;
        instr_t ins;
        int st, bc;
        bit done;

        do_reset();

        // Forwarding distance 1, 2, 3.
        nops(2);
        issue(alu(3, 1, 2), st, o);
        cyc(alu(4, 3, 5), o);
        check("fwd_ex_a", 32'(o.fa), 32'd1);
        check("fwd_ex_b", 32'(o.fb), 32'd0);
        nops(2);
        issue(alu(3, 1, 2), st, o);
        nops(1);
        cyc(alu(4, 3, 5), o);
        check("fwd_mem_a", 32'(o.fa), 32'd2);
        nops(2);
        issue(alu(3, 1, 2), st, o);
        nops(2);
        cyc(alu(4, 3, 5), o);
        check("fwd_wb_a", 32'(o.fa), 32'd0);

        // Double hazard: younger writer wins on both operands.
        nops(2);
        issue(alu(3, 1, 2), st, o);
        issue(alu(3, 1, 2), st, o);
        cyc(alu(6, 3, 3), o);
        check("dbl_fwd_a", 32'(o.fa), 32'd1);
        check("dbl_fwd_b", 32'(o.fb), 32'd1);

        // Load-use: one bubble, then MEM forwarding.
        nops(2);
        issue(lw(8, 1), st, o);
        cyc(alu(9, 8, 8), o);
        check("lu_stall", 32'(o.stall), 32'd1);
        check("lu_flush_idex", 32'(o.fx), 32'd1);
        issue(alu(9, 8, 8), st, o);
        check("lu_stall_count", 32'(st), 32'd0);
        check("lu_fwd_a", 32'(o.fa), 32'd2);
        check("lu_fwd_b", 32'(o.fb), 32'd2);

        // Load to r0 never stalls.
        nops(2);
        issue(lw(0, 1), st, o);
        issue(alu(9, 0, 0), st, o);
        check("r0_stalls", 32'(st), 32'd0);
        check("r0_fwd_a", 32'(o.fa), 32'd0);

        // Mul/div: mfhi waits out the busy window.
        nops(2);
        issue(mult(1, 2), st, o);
        check("mult_nostall", 32'(st), 32'd0);
        bc = 0;
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            cyc(mfhi(10), o);
            if (o.busy) bc++;
            if (!o.stall) done = 1;
        end
        check("md_busy_cycles", 32'(bc), 32'd4);
        check("mfhi_issue_busy", 32'(o.busy), 32'd0);
        cyc(nop(), o);
        check("after_mfhi_stall", 32'(o.stall), 32'd0);
        issue(mult(1, 2), st, o);
        issue(mult(3, 4), st, o);
        check("mult2_stalls", 32'(st), 32'd4);
        nops(5);

        // Branch overrides a pending load-use stall and kills the ID entry.
        issue(lw(8, 1), st, o);
        ins = alu(9, 8, 8);
        ins.br = 1;
        cyc(ins, o);
        check("br_stall", 32'(o.stall), 32'd0);
        check("br_flush_ifid", 32'(o.fi), 32'd1);
        check("br_flush_idex", 32'(o.fx), 32'd1);
        cyc(alu(10, 9, 8), o);
        check("br_ex_killed", 32'(o.fa), 32'd0);
        check("br_mem_load", 32'(o.fb), 32'd2);

        // Reset during mul/div busy with counter at 2.
        nops(2);
        issue(mult(1, 2), st, o);
        cyc(nop(), o);
        check("pre_rst_busy", 32'(o.busy), 32'd1);
        do_reset();
        cyc(mfhi(10), o);
        check("post_rst_stall", 32'(o.stall), 32'd0);
        check("post_rst_busy", 32'(o.busy), 32'd0);
        check("post_rst_fwd_a", 32'(o.fa), 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                ins = nop();
                ins.rs   = 5'($urandom_range(0, 3));
                ins.rt   = 5'($urandom_range(0, 3));
                ins.urs  = 1'($urandom_range(0, 1));
                ins.urt  = 1'($urandom_range(0, 1));
                ins.wr   = 1'($urandom_range(0, 1));
                ins.wdst = 5'($urandom_range(0, 3));
                ins.ld   = ins.wr && ($urandom_range(0, 2) == 0);
                ins.md   = ($urandom_range(0, 7) == 0);
                ins.hilo = ($urandom_range(0, 7) == 0);
                ins.br   = ($urandom_range(0, 9) == 0);
                cyc(ins, o);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
